// File: rtl/mac_row_seq.sv
// -----------------------------------------------------------------------------
// mac_row_seq
//
// Sequencer for one mac_row instance. A start command runs one pass:
//   1. accept `col` weights from the weight stream and issue them as load
//      instructions (inst_w = 01),
//   2. spend one idle gap cycle,
//   3. accept `num_act` activations from the activation stream and issue them
//      as execute instructions (inst_w = 10),
//   4. wait drain_cyc cycles for the row pipeline to empty, sample the row's
//      valid vector, then pulse done.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      begin a pass (only looked at in IDLE)
//   num_act    activations in the pass, 0..max_act (larger values clamp)
//   w_data     weight stream data
//   w_valid    weight stream valid
//   w_ready    weight stream ready (high only while loading weights)
//   a_data     activation stream data
//   a_valid    activation stream valid
//   a_ready    activation stream ready (high only while executing)
//   row_valid  valid vector from mac_row
//   in_w       registered data to mac_row
//   inst_w     registered instruction to mac_row: 00 idle, 01 load, 10 execute
//   busy       pass in progress
//   done       one-cycle completion pulse
//   valid_ok   &row_valid from the last drain cycle, held until next start
//
// drain_cyc must be at least col+1 so the last execute has travelled through
// every column before row_valid is sampled.
// -----------------------------------------------------------------------------
module mac_row_seq #(
  parameter int bw        = 4,
  parameter int col       = 8,
  parameter int max_act   = 64,
  parameter int drain_cyc = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(max_act):0]     num_act,
  input  logic [bw-1:0]                w_data,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [bw-1:0]                a_data,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [col-1:0]               row_valid,
  output logic [bw-1:0]                in_w,
  output logic [1:0]                   inst_w,
  output logic                         busy,
  output logic                         done,
  output logic                         valid_ok
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int na_w = $clog2(max_act) + 1;   // holds 0..max_act
  localparam int wc_w = $clog2(col + 1);       // holds 0..col
  localparam int dc_w = $clog2(drain_cyc + 1); // holds 0..drain_cyc

  localparam logic [na_w-1:0] max_act_v  = na_w'(max_act);
  localparam logic [wc_w-1:0] last_w_v   = wc_w'(col - 1);
  localparam logic [dc_w-1:0] last_d_v   = dc_w'(drain_cyc - 1);

  localparam logic [1:0] inst_idle = 2'b00;
  localparam logic [1:0] inst_load = 2'b01;
  localparam logic [1:0] inst_exec = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    GAP,
    EXEC,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [wc_w-1:0] w_cnt;     // weight handshakes so far in this pass
  logic [na_w-1:0] a_cnt;     // activation handshakes so far in this pass
  logic [dc_w-1:0] d_cnt;     // drain cycles elapsed
  logic [na_w-1:0] num_lat;   // clamped activation count for this pass

  logic [na_w-1:0] num_eff;
  logic            w_hs;
  logic            a_hs;
  logic            last_w;
  logic            last_a;
  logic            last_drain;
  logic            start_ok;
  logic            start_zero;

  // ---------------------------------------------------------------------------
  // Handshake and terminal-count decode
  // ---------------------------------------------------------------------------
  assign num_eff    = (num_act > max_act_v) ? max_act_v : num_act;
  assign w_hs       = w_valid & w_ready;
  assign a_hs       = a_valid & a_ready;
  assign last_w     = w_hs && (w_cnt == last_w_v);
  // num_lat is never 0 inside EXEC, so num_lat-1 cannot underflow here.
  assign last_a     = a_hs && (a_cnt == (num_lat - na_w'(1)));
  assign last_drain = (state == DRAIN) && (d_cnt == last_d_v);
  assign start_ok   = (state == IDLE) && start && (num_eff != '0);
  assign start_zero = (state == IDLE) && start && (num_eff == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)   state_nxt = LOAD_W;
      LOAD_W:  if (last_w)     state_nxt = GAP;
      GAP:                     state_nxt = EXEC;
      EXEC:    if (last_a)     state_nxt = DRAIN;
      DRAIN:   if (last_drain) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    a_ready = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE:    busy    = 1'b0;
      LOAD_W:  w_ready = 1'b1;
      EXEC:    a_ready = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, instruction issue and completion status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_cnt    <= '0;
      a_cnt    <= '0;
      d_cnt    <= '0;
      num_lat  <= '0;
      in_w     <= '0;
      inst_w   <= inst_idle;
      done     <= 1'b0;
      valid_ok <= 1'b0;
    end else begin
      // Bubble unless a handshake below issues something; in_w keeps its value.
      inst_w <= inst_idle;
      done   <= 1'b0;

      if (start_ok || start_zero) begin
        num_lat  <= num_eff;
        valid_ok <= 1'b0;
        w_cnt    <= '0;
        a_cnt    <= '0;
        d_cnt    <= '0;
      end

      // A zero-length pass completes immediately without touching the row.
      if (start_zero) begin
        done <= 1'b1;
      end

      if (w_hs) begin
        in_w   <= w_data;
        inst_w <= inst_load;
        w_cnt  <= last_w ? '0 : w_cnt + wc_w'(1);
      end

      if (a_hs) begin
        in_w   <= a_data;
        inst_w <= inst_exec;
        a_cnt  <= last_a ? '0 : a_cnt + na_w'(1);
      end

      if (state == DRAIN) begin
        d_cnt <= last_drain ? '0 : d_cnt + dc_w'(1);
        if (last_drain) begin
          valid_ok <= &row_valid;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_row_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_row_seq
//
// Self-checking bench for mac_row_seq. Each pass pre-generates per-cycle
// stimulus, derives the expected handshake schedule from the pass rules
// (first col weight valids from cycle 1, one gap, first num_act activation
// valids after it, drain_cyc cycles to done) and compares every output in
// every cycle. A directed table covers the named scenarios, a hand-written
// sequence covers mid-pass reset, and random passes follow.
// -----------------------------------------------------------------------------
module tb_mac_row_seq;

  localparam int BW      = 4;
  localparam int COL     = 8;
  localparam int MAX_ACT = 64;
  localparam int DRAIN   = 10;
  localparam int NAW     = $clog2(MAX_ACT) + 1;
  localparam int MAXC    = 700;
  localparam int FORCE_K = 400;   // random valids forced high from here on

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NAW-1:0]  num_act;
  logic [BW-1:0]   w_data;
  logic            w_valid;
  logic            w_ready;
  logic [BW-1:0]   a_data;
  logic            a_valid;
  logic            a_ready;
  logic [COL-1:0]  row_valid;
  logic [BW-1:0]   in_w;
  logic [1:0]      inst_w;
  logic            busy;
  logic            done;
  logic            valid_ok;

  always #5 clk = ~clk;

  mac_row_seq #(
    .bw(BW), .col(COL), .max_act(MAX_ACT), .drain_cyc(DRAIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .row_valid(row_valid), .in_w(in_w), .inst_w(inst_w),
    .busy(busy), .done(done), .valid_ok(valid_ok)
  );

  int checks = 0;
  int errors = 0;
  int cur_k  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_k, act, exp);
    end
  endtask

  // Per-cycle stimulus of the current pass, indexed by cycle (start = cycle 0).
  logic           wv [MAXC];
  logic           av [MAXC];
  logic [BW-1:0]  wd [MAXC];
  logic [BW-1:0]  ad [MAXC];
  logic [COL-1:0] rv [MAXC];
  logic           st [MAXC];
  logic [NAW-1:0] sn [MAXC];
  logic           e_whs [MAXC];
  logic           e_ahs [MAXC];

  // Model state carried between passes.
  logic [BW-1:0] last_in  = '0;
  logic          prev_vok = 1'b0;

  typedef struct {
    int          num;
    int          wmode;     // 0 held high, 1 toggle (high on even cycles), 2 random
    int          amode;
    logic [3:0]  wdc;
    logic [3:0]  adc;
    logic        rdata;     // random data instead of constant
    logic [7:0]  rv_last;   // row_valid in the last drain cycle
    logic        bstart;    // pulse start while busy
    int          exp_done;
    logic        exp_vok;
  } vec_t;

  vec_t tbl [9];

  function automatic logic valid_of(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 2) == 0;
    if (k >= FORCE_K) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_idle();
    start     = 1'b0;
    num_act   = '0;
    w_valid   = 1'b0;
    a_valid   = 1'b0;
    w_data    = '0;
    a_data    = '0;
    row_valid = '0;
  endtask

  // Runs one pass; abort_at >= 0 drives reset low in that cycle and stops.
  task automatic run_pass(input int num, input int wmode, input int amode,
                          input logic [3:0] wdc, input logic [3:0] adc,
                          input logic rdata, input logic [7:0] rvl,
                          input logic bstart, input int abort_at,
                          output int obs_done, output logic obs_vok,
                          output int exp_done);
    int ne, cnt, k, last_w, gap, last_a, done_c, k_end;
    logic vok_fin;
    logic [BW-1:0] cur_in;
    logic [1:0] inst_e;

    for (int i = 0; i < MAXC; i++) begin
      wv[i] = valid_of(wmode, i);
      av[i] = valid_of(amode, i);
      wd[i] = rdata ? BW'($urandom) : wdc;
      ad[i] = rdata ? BW'($urandom) : adc;
      rv[i] = COL'($urandom);
      st[i] = 1'b0;
      sn[i] = '0;
      e_whs[i] = 1'b0;
      e_ahs[i] = 1'b0;
    end
    st[0] = 1'b1;
    sn[0] = NAW'(num);

    ne = (num > MAX_ACT) ? MAX_ACT : num;
    last_w = 0; gap = 0; last_a = 0;
    if (ne == 0) begin
      done_c = 1;
    end else begin
      k = 1; cnt = 0;
      while (cnt < COL) begin
        if (wv[k]) begin e_whs[k] = 1'b1; cnt++; last_w = k; end
        k++;
      end
      gap = last_w + 1;
      k = gap + 1; cnt = 0;
      while (cnt < ne) begin
        if (av[k]) begin e_ahs[k] = 1'b1; cnt++; last_a = k; end
        k++;
      end
      done_c = last_a + 1 + DRAIN;
      rv[done_c-1] = rvl;
    end
    vok_fin  = (ne == 0) ? 1'b0 : &rv[done_c-1];
    exp_done = done_c;

    if (bstart) begin
      for (int i = 1; i < done_c; i++) begin
        st[i] = 1'b1;
        sn[i] = NAW'($urandom_range(0, 70));
      end
    end

    obs_done = -1;
    obs_vok  = 1'b0;
    cur_in   = last_in;
    k_end    = (abort_at >= 0) ? abort_at : done_c + 1;

    for (int kk = 0; kk <= k_end; kk++) begin
      cur_k = kk;
      inst_e = 2'b00;
      if (kk >= 1 && e_whs[kk-1]) begin inst_e = 2'b01; cur_in = wd[kk-1]; end
      if (kk >= 1 && e_ahs[kk-1]) begin inst_e = 2'b10; cur_in = ad[kk-1]; end

      check("inst_w", int'(inst_w), int'(inst_e));
      check("in_w", int'(in_w), int'(cur_in));
      check("busy", int'(busy), int'(ne > 0 && kk >= 1 && kk < done_c));
      check("w_ready", int'(w_ready), int'(ne > 0 && kk >= 1 && kk <= last_w));
      check("a_ready", int'(a_ready), int'(ne > 0 && kk > gap && kk <= last_a));
      check("done", int'(done), int'(kk == done_c));
      check("valid_ok", int'(valid_ok),
            int'((kk == 0) ? prev_vok : (kk < done_c) ? 1'b0 : vok_fin));
      if (done && obs_done < 0) begin
        obs_done = kk;
        obs_vok  = valid_ok;
      end

      start     = st[kk];
      num_act   = sn[kk];
      w_valid   = wv[kk];
      w_data    = wd[kk];
      a_valid   = av[kk];
      a_data    = ad[kk];
      row_valid = rv[kk];
      reset     = (kk == abort_at) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end

    if (abort_at < 0) begin
      last_in  = cur_in;
      prev_vok = vok_fin;
    end
  endtask

  initial begin
    int od, ed;
    logic ov;

    //           num wm am  wd    ad    rd    rv_last bs    done vok
    tbl[0] = '{  8, 0, 0, 4'hA, 4'h5, 1'b0, 8'hFF, 1'b0, 28, 1'b1};
    tbl[1] = '{  8, 1, 0, 4'hA, 4'h5, 1'b0, 8'hFF, 1'b0, 36, 1'b1};
    tbl[2] = '{  0, 0, 0, 4'hA, 4'h5, 1'b0, 8'hFF, 1'b0,  1, 1'b0};
    tbl[3] = '{  8, 0, 0, 4'hA, 4'h5, 1'b0, 8'hFF, 1'b1, 28, 1'b1};
    tbl[4] = '{  8, 0, 0, 4'hA, 4'h5, 1'b0, 8'h7F, 1'b0, 28, 1'b0};
    tbl[5] = '{100, 0, 0, 4'h0, 4'h0, 1'b1, 8'hFF, 1'b0, 84, 1'b1};
    tbl[6] = '{ 64, 0, 0, 4'h0, 4'h0, 1'b1, 8'hFF, 1'b0, 84, 1'b1};
    tbl[7] = '{  1, 0, 1, 4'h3, 4'hC, 1'b0, 8'hFF, 1'b0, 21, 1'b1};
    tbl[8] = '{  3, 1, 1, 4'h0, 4'h0, 1'b1, 8'hFF, 1'b0, 33, 1'b1};

    // Reset state.
    drive_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur_k = 0;
    check("rst_inst_w", int'(inst_w), 0);
    check("rst_in_w", int'(in_w), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_w_ready", int'(w_ready), 0);
    check("rst_a_ready", int'(a_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_valid_ok", int'(valid_ok), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed passes.
    foreach (tbl[i]) begin
      run_pass(tbl[i].num, tbl[i].wmode, tbl[i].amode, tbl[i].wdc, tbl[i].adc,
               tbl[i].rdata, tbl[i].rv_last, tbl[i].bstart, -1, od, ov, ed);
      check($sformatf("done_cycle_vec%0d", i), od, tbl[i].exp_done);
      check($sformatf("valid_ok_vec%0d", i), int'(ov), int'(tbl[i].exp_vok));
    end

    // Reset in the 4th EXEC cycle aborts the pass.
    run_pass(8, 0, 0, 4'h9, 4'h6, 1'b0, 8'hFF, 1'b0, COL + 5, od, ov, ed);
    cur_k = COL + 6;
    check("abort_inst_w", int'(inst_w), 0);
    check("abort_in_w", int'(in_w), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_w_ready", int'(w_ready), 0);
    check("abort_a_ready", int'(a_ready), 0);
    check("abort_valid_ok", int'(valid_ok), 0);
    reset = 1'b1;
    drive_idle();
    last_in  = '0;
    prev_vok = 1'b0;
    for (int i = 0; i < DRAIN + 4; i++) begin
      check("abort_no_done", int'(done), 0);
      check("abort_idle_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
    run_pass(8, 0, 0, 4'hA, 4'h5, 1'b0, 8'hFF, 1'b0, -1, od, ov, ed);
    check("post_abort_done_cycle", od, 28);
    check("post_abort_valid_ok", int'(ov), 1);

    // Random passes against the schedule model.
    for (int p = 0; p < 20; p++) begin
      run_pass($urandom_range(0, 70), $urandom_range(0, 2), $urandom_range(0, 2),
               4'h0, 4'h0, 1'b1,
               ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom),
               1'($urandom_range(0, 1)), -1, od, ov, ed);
      check($sformatf("rand_done_cycle_%0d", p), od, ed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
